flag_sprite_fetch: RTL and testbench
====================================

# flag_sprite_fetch

Address generator and output stage for the 80×60 flag sprite. Each cycle it takes the VGA beam coordinate, decides whether it lies inside the flag's on-screen rectangle, and drives the flag ROM read address. It then takes the 4-bit palette index that the ROM returns one cycle later and presents it, aligned and with a hit flag, to the colour mapper. It also owns the flag's per-frame position latch and a show/blink state machine, so the sprite never tears mid-frame.

## Interface
- SPR_W, 80: sprite width in pixels (ROM row pitch).
- SPR_H, 60: sprite height in pixels.
- TRANSP_IDX, 4'h0: palette index treated as transparent.
- BLINK_FRAMES, 16: frames per blink half-period (1..31).
- Clk  in  1  system/pixel clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- DrawX  in  10  current beam column (0..639).
- DrawY  in  10  current beam row (0..479).
- pos_x  in  10  requested sprite top-left column; sampled only on frame_start.
- pos_y  in  10  requested sprite top-left row; sampled only on frame_start.
- show  in  1  sprite enable; sampled only on frame_start.
- blink_en  in  1  blink enable; sampled only on frame_start.
- rom_addr  out  13  registered read address to flag ROM (row*SPR_W + col).
- rom_data  in  4  ROM palette index, valid one cycle after rom_addr.
- pixel_idx  out  4  palette index for the beam coordinate of 3 cycles earlier.
- pixel_hit  out  1  1 when pixel_idx is an opaque sprite pixel.

## Operation
- Frame latch: on frame_start, lat_x<=pos_x and lat_y<=pos_y. The state machine advances on the same edge. Latched values are used for the whole following frame.
- Hit test uses 11-bit arithmetic, so a sprite near the right or bottom edge does not wrap:
  - in_x = DrawX >= lat_x && DrawX < lat_x + SPR_W.
  - in_y = DrawY >= lat_y && DrawY < lat_y + SPR_H.
  - in_rect = in_x && in_y && vis, where vis = state in {ON, BLINK_ON}.
- Address: if in_rect, rom_addr <= (DrawY-lat_y)*SPR_W + (DrawX-lat_x), range 0..4799. Otherwise rom_addr <= 0. No address above 4799 is ever driven.
- Pipeline flag: hit_d1 <= in_rect, then hit_d2 <= hit_d1. hit_d2 is aligned with rom_data.
- Output register:
  - pixel_idx <= hit_d2 ? rom_data : 0.
  - pixel_hit <= hit_d2 && (rom_data != TRANSP_IDX).
- State machine (states OFF, ON, BLINK_ON, BLINK_OFF; transitions only on frame_start):
  - any state, show=0 -> OFF; frame counter cleared.
  - OFF, show=1 -> blink_en ? BLINK_ON : ON.
  - ON, show=1, blink_en=1 -> BLINK_ON, counter cleared.
  - BLINK_ON/BLINK_OFF, blink_en=0 -> ON.
  - BLINK_ON/BLINK_OFF, blink_en=1: counter increments. When counter reaches BLINK_FRAMES-1 it clears and the state toggles BLINK_ON<->BLINK_OFF.
- Frame counter: 5 bits; never exceeds BLINK_FRAMES-1.

## Timing
- Reset values: rom_addr=0, pixel_idx=0, pixel_hit=0, hit_d1=hit_d2=0, lat_x=lat_y=0, state=OFF, counter=0.
- Reset mid-frame: all outputs are 0 from the next cycle on. The sprite stays invisible until a frame_start with show=1.
- Latency: coordinate presented in cycle N -> rom_addr valid in N+1 -> rom_data valid in N+2 -> pixel_idx/pixel_hit valid in N+3. The latency is fixed, including across sprite edges.
- frame_start and the pixel pipeline are independent. Pixels already in flight complete using the visibility in effect when they entered.
- pos_x/pos_y changes between frame_starts have no effect.
- Reset together with frame_start: reset wins.

## Test plan
- Reset, then frame_start with show=1, blink_en=0, pos=(100,50); sweep DrawX=100..179 at DrawY=50 -> rom_addr 0..79 one cycle later; pixel_hit follows rom_data!=0 three cycles after each coordinate.
- Corner pixel: pos=(100,50), beam (179,109) -> rom_addr=4799. Beam (180,109) and (179,110) -> rom_addr=0, pixel_hit=0.
- Right-edge clip: pos=(600,450), beam sweep to (639,479) -> addresses only for col<40 and row<30; no wrap and no hit at DrawX<600.
- Mid-frame pos_x change from 100 to 300 without frame_start -> hits remain at 100..179 until the next frame_start, then move to 300..379.
- Blink: BLINK_FRAMES=2, show=1, blink_en=1 -> visibility over successive frames is on,on,off,off,on. Dropping blink_en -> ON at the next frame_start.
- Reset asserted while in BLINK_OFF with hits in flight -> pixel_hit=0 the next cycle; state OFF; rom_addr=0.

Source files
------------

// File: rtl/flag_sprite_fetch_if.sv
// Beam coordinate, flag ROM port and pixel output of the flag sprite.
// master = fetch stage side, slave = beam source / ROM / colour mapper side.
interface flag_sprite_fetch_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [12:0] rom_addr;
   logic [3:0]  rom_data;
   logic [3:0]  pixel_idx;
   logic        pixel_hit;

   modport master (
      input  DrawX,
      input  DrawY,
      input  rom_data,
      output rom_addr,
      output pixel_idx,
      output pixel_hit
   );

   modport slave (
      output DrawX,
      output DrawY,
      output rom_data,
      input  rom_addr,
      input  pixel_idx,
      input  pixel_hit
   );
endinterface

// File: rtl/flag_sprite_fetch.sv
// Flag sprite address generator, pixel output stage and show/blink control.
// Position and visibility change only at frame_start so the sprite never tears.
module flag_sprite_fetch #(
   parameter int unsigned SPR_W        = 80,
   parameter int unsigned SPR_H        = 60,
   parameter logic [3:0]  TRANSP_IDX   = 4'h0,
   parameter int unsigned BLINK_FRAMES = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_start,
   input  logic [9:0]          pos_x,
   input  logic [9:0]          pos_y,
   input  logic                show,
   input  logic                blink_en,
   flag_sprite_fetch_if.master bus
);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_ON,
      ST_BLINK_ON,
      ST_BLINK_OFF
   } state_t;

   localparam logic [4:0]  CNT_LAST = 5'(BLINK_FRAMES - 1);
   localparam logic [10:0] W11      = 11'(SPR_W);
   localparam logic [10:0] H11      = 11'(SPR_H);
   localparam logic [12:0] W13      = 13'(SPR_W);

   state_t      state;
   state_t      state_nx;
   logic [4:0]  cnt;
   logic [4:0]  cnt_nx;
   logic [9:0]  lat_x;
   logic [9:0]  lat_y;

   logic        vis;
   logic        in_x;
   logic        in_y;
   logic        in_rect;
   logic [10:0] bx;
   logic [10:0] by;
   logic [10:0] lx;
   logic [10:0] ly;
   logic [9:0]  dx;
   logic [9:0]  dy;
   logic [12:0] addr_nx;

   logic        hit_d1;
   logic        hit_d2;

   // Sample the requested position once per frame
   always_ff @(posedge Clk) begin
      if (Reset) begin
         lat_x <= '0;
         lat_y <= '0;
      end else if (frame_start) begin
         lat_x <= pos_x;
         lat_y <= pos_y;
      end
   end

   // Show/blink state and frame counter registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_OFF;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state: moves only at frame_start, show=0 always wins
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (frame_start) begin
         if (!show) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
         end else begin
            case (state)
               ST_OFF: begin
                  state_nx = blink_en ? ST_BLINK_ON : ST_ON;
                  cnt_nx   = '0;
               end
               ST_ON: begin
                  if (blink_en) begin
                     state_nx = ST_BLINK_ON;
                  end
                  cnt_nx = '0;
               end
               ST_BLINK_ON,
               ST_BLINK_OFF: begin
                  if (!blink_en) begin
                     state_nx = ST_ON;
                     cnt_nx   = '0;
                  end else if (cnt >= CNT_LAST) begin
                     cnt_nx   = '0;
                     state_nx = (state == ST_BLINK_ON) ?
                                ST_BLINK_OFF : ST_BLINK_ON;
                  end else begin
                     cnt_nx = cnt + 5'd1;
                  end
               end
               default: begin
                  state_nx = ST_OFF;
                  cnt_nx   = '0;
               end
            endcase
         end
      end
   end

   // Rectangle test in 11 bits so edges near 640/480 do not wrap
   always_comb begin
      bx      = {1'b0, bus.DrawX};
      by      = {1'b0, bus.DrawY};
      lx      = {1'b0, lat_x};
      ly      = {1'b0, lat_y};
      vis     = (state == ST_ON) || (state == ST_BLINK_ON);
      in_x    = (bx >= lx) && (bx < (lx + W11));
      in_y    = (by >= ly) && (by < (ly + H11));
      in_rect = in_x && in_y && vis;
   end

   // Sprite-local offset to ROM address; zero outside the sprite
   always_comb begin
      dx      = bus.DrawX - lat_x;
      dy      = bus.DrawY - lat_y;
      addr_nx = '0;
      if (in_rect) begin
         addr_nx = (13'(dy) * W13) + 13'(dx);
      end
   end

   // ROM address register and hit flag aligned with rom_data
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.rom_addr <= '0;
         hit_d1       <= 1'b0;
         hit_d2       <= 1'b0;
      end else begin
         bus.rom_addr <= addr_nx;
         hit_d1       <= in_rect;
         hit_d2       <= hit_d1;
      end
   end

   // Output stage: mask data outside the sprite, flag opaque pixels
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.pixel_idx <= '0;
         bus.pixel_hit <= 1'b0;
      end else begin
         bus.pixel_idx <= hit_d2 ? bus.rom_data : 4'h0;
         bus.pixel_hit <= hit_d2 && (bus.rom_data != TRANSP_IDX);
      end
   end

endmodule

// File: tb/tb_flag_sprite_fetch.sv
// Testbench for flag_sprite_fetch: ROM model, table vectors and a
// latency-tagged scoreboard for rom_addr and the pixel outputs.
module tb_flag_sprite_fetch;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_start;
   logic       show;
   logic       blink_en;
   logic [9:0] pos_x;
   logic [9:0] pos_y;

   flag_sprite_fetch_if bus ();

   flag_sprite_fetch #(
      .SPR_W       (80),
      .SPR_H       (60),
      .TRANSP_IDX  (4'h0),
      .BLINK_FRAMES(2)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_start(frame_start),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .show       (show),
      .blink_en   (blink_en),
      .bus        (bus)
   );

   always #5 Clk = ~Clk;

   logic [3:0] rom [0:4799];

   initial begin
      for (int i = 0; i < 4800; i++) begin
         rom[i] = 4'(((i * 3) + (i / 80)) % 11);
      end
   end

   always @(posedge Clk) begin
      if (bus.rom_addr < 13'd4800) begin
         bus.rom_data <= rom[bus.rom_addr];
      end else begin
         bus.rom_data <= 4'hF;
      end
   end

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [12:0] addr;
      logic [3:0]  idx;
      logic        hit;
   } exp_t;

   typedef struct {
      int          x;
      int          y;
      logic [12:0] addr;
      bit          in_r;
   } vec_t;

   exp_t aq[$];
   exp_t pq[$];

   int n_chk  = 0;
   int n_fail = 0;

   int mx   = 0;
   int my   = 0;
   bit mvis = 1'b0;

   task automatic check(input string name,
                        input logic [15:0] act,
                        input logic [15:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   task automatic check_due();
      exp_t e;
      while (aq.size() > 0 && aq[0].due <= cyc) begin
         e = aq.pop_front();
         if (e.due == cyc) begin
            check("rom_addr", 16'(bus.rom_addr), 16'(e.addr));
         end
      end
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         e = pq.pop_front();
         if (e.due == cyc) begin
            check("pixel_idx", 16'(bus.pixel_idx), 16'(e.idx));
            check("pixel_hit", 16'(bus.pixel_hit), 16'(e.hit));
         end
      end
   endtask

   function automatic bit m_in(input int x, input int y);
      return mvis && (x >= mx) && (x < mx + 80) &&
             (y >= my) && (y < my + 60);
   endfunction

   function automatic int m_addr(input int x, input int y);
      return ((y - my) * 80) + (x - mx);
   endfunction

   task automatic step(input int x, input int y, input bit fs,
                       input logic [12:0] ea, input bit ein,
                       input bit nv);
      exp_t e;
      @(negedge Clk);
      check_due();
      bus.DrawX   = 10'(x);
      bus.DrawY   = 10'(y);
      frame_start = fs;
      e.addr = ein ? ea : 13'd0;
      e.idx  = ein ? rom[ea] : 4'h0;
      e.hit  = ein && (e.idx != 4'h0);
      e.due  = cyc + 1;
      aq.push_back(e);
      e.due  = cyc + 3;
      pq.push_back(e);
      if (fs) begin
         mx   = int'(pos_x);
         my   = int'(pos_y);
         mvis = nv;
      end
   endtask

   task automatic pix(input int x, input int y);
      bit i;
      i = m_in(x, y);
      step(x, y, 1'b0, i ? 13'(m_addr(x, y)) : 13'd0, i, mvis);
   endtask

   task automatic frame(input int px, input int py,
                        input bit sh, input bit be, input bit nv);
      bit i;
      pos_x    = 10'(px);
      pos_y    = 10'(py);
      show     = sh;
      blink_en = be;
      i = m_in(0, 0);
      step(0, 0, 1'b1, i ? 13'(m_addr(0, 0)) : 13'd0, i, nv);
   endtask

   task automatic do_reset(input bit with_fs);
      @(negedge Clk);
      check_due();
      aq.delete();
      pq.delete();
      Reset       = 1'b1;
      frame_start = with_fs;
      show        = 1'b1;
      @(negedge Clk);
      check("rst rom_addr", 16'(bus.rom_addr), 16'd0);
      check("rst pixel_hit", 16'(bus.pixel_hit), 16'd0);
      check("rst pixel_idx", 16'(bus.pixel_idx), 16'd0);
      Reset       = 1'b0;
      frame_start = 1'b0;
      mx   = 0;
      my   = 0;
      mvis = 1'b0;
   endtask

   vec_t corner [8];
   vec_t edge_v [5];
   bit   blink_vis [5];

   initial begin
      corner[0] = '{100,  50,   13'd0, 1'b1};
      corner[1] = '{179, 109, 13'd4799, 1'b1};
      corner[2] = '{180, 109,   13'd0, 1'b0};
      corner[3] = '{179, 110,   13'd0, 1'b0};
      corner[4] = '{ 99,  50,   13'd0, 1'b0};
      corner[5] = '{100,  49,   13'd0, 1'b0};
      corner[6] = '{179,  50,  13'd79, 1'b1};
      corner[7] = '{100, 109, 13'd4720, 1'b1};

      edge_v[0] = '{639, 479, 13'd2359, 1'b1};
      edge_v[1] = '{600, 450,    13'd0, 1'b1};
      edge_v[2] = '{599, 479,    13'd0, 1'b0};
      edge_v[3] = '{639, 449,    13'd0, 1'b0};
      edge_v[4] = '{620, 470, 13'd1620, 1'b1};

      blink_vis[0] = 1'b1;
      blink_vis[1] = 1'b1;
      blink_vis[2] = 1'b0;
      blink_vis[3] = 1'b0;
      blink_vis[4] = 1'b1;

      Reset       = 1'b1;
      frame_start = 1'b0;
      show        = 1'b0;
      blink_en    = 1'b0;
      pos_x       = '0;
      pos_y       = '0;
      bus.DrawX   = '0;
      bus.DrawY   = '0;
      repeat (3) @(negedge Clk);
      check("reset rom_addr", 16'(bus.rom_addr), 16'd0);
      check("reset pixel_idx", 16'(bus.pixel_idx), 16'd0);
      check("reset pixel_hit", 16'(bus.pixel_hit), 16'd0);
      Reset = 1'b0;

      // invisible before the first frame_start
      pix(120, 60);
      pix(0, 0);

      // row sweep across the sprite at pos (100,50)
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      for (int x = 95; x <= 185; x++) pix(x, 50);

      // corner and boundary vectors
      for (int k = 0; k < 8; k++) begin
         step(corner[k].x, corner[k].y, 1'b0,
              corner[k].addr, corner[k].in_r, mvis);
      end

      // position change without frame_start has no effect
      pos_x = 10'd300;
      for (int x = 90; x <= 390; x += 2) pix(x, 55);
      frame(300, 50, 1'b1, 1'b0, 1'b1);
      for (int x = 90; x <= 390; x += 2) pix(x, 55);

      // bottom-right clipping
      frame(600, 450, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(edge_v[k].x, edge_v[k].y, 1'b0,
              edge_v[k].addr, edge_v[k].in_r, mvis);
      end
      for (int y = 445; y <= 479; y++) begin
         for (int x = 590; x <= 639; x++) pix(x, y);
      end

      // blink sequence on,on,off,off,on
      for (int k = 0; k < 5; k++) begin
         frame(100, 50, 1'b1, 1'b1, blink_vis[k]);
         pix(120, 60);
         pix(179, 109);
      end
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      pix(120, 60);
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      pix(120, 60);
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      pix(120, 60);

      // reset in BLINK_OFF with hits in flight
      frame(100, 50, 1'b1, 1'b1, 1'b1);
      pix(120, 60);
      frame(100, 50, 1'b1, 1'b1, 1'b1);
      for (int x = 101; x <= 108; x++) pix(x, 50);
      frame(100, 50, 1'b1, 1'b1, 1'b0);
      do_reset(1'b0);
      for (int x = 101; x <= 106; x++) pix(x, 50);
      pix(120, 60);

      // reset together with frame_start: reset wins
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      pix(120, 60);
      pix(121, 60);
      do_reset(1'b1);
      pix(120, 60);
      pix(20, 10);
      pix(0, 0);
      pix(121, 60);
      frame(100, 50, 1'b1, 1'b0, 1'b1);
      pix(120, 60);
      pix(179, 109);

      repeat (4) pix(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
